// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory target for the MEM stage. Accepts one load/store
//            request at a time on a valid/ready request channel, waits a
//            fixed number of cycles, commits the access, then presents the
//            result on a valid/ready response channel until it is taken.
//            Word and byte accesses, little-endian byte lanes, sign-extended
//            byte loads.
// Optional : `define DMEM_ERR_EN to flag misaligned word accesses and
//            out-of-range addresses on rsp_err. Without it rsp_err is tied
//            low, word accesses ignore addr[1:0] and addresses wrap.
// Ports    : clk        - clock, rising edge
//            reset_n    - asynchronous active-low reset
//            req_valid  - request present
//            req_ready  - responder can accept a request (idle)
//            req_write  - 1 = store, 0 = load
//            req_word   - 1 = 32-bit word, 0 = byte
//            req_addr   - byte address
//            req_wdata  - store data (byte stores use [7:0])
//            rsp_valid  - response present
//            rsp_ready  - requester accepts the response
//            rsp_rdata  - load data, 0 for stores and errors
//            rsp_err    - access error (DMEM_ERR_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_waitCnt;
    logic [3:0]  w_nextWaitCnt;
    logic        w_capture;
    logic        w_commit;

    // Captured request
    logic        r_write;
    logic        r_word;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // Access fields used on the commit edge. With zero wait states the commit
    // happens on the acceptance edge itself, so the live request is used.
    logic        w_accWrite;
    logic        w_accWord;
    logic [31:0] w_accAddr;
    logic [31:0] w_accWdata;
    logic [c_IDX_W-1:0] w_accIdx;
    logic [1:0]  w_lane;
    logic        w_accErr;

    logic [31:0] w_memWord;
    logic [31:0] w_laneShifted;
    logic [31:0] w_loadData;

    logic [31:0] r_rspRdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_waitCnt <= 4'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_capture     = 1'b0;
        w_commit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_nextState = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_nextState   = S_WAIT;
                        w_nextWaitCnt = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_nextState = S_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_nextWaitCnt = r_waitCnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);

    // ------------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_word  <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_capture) begin
            r_write <= req_write;
            r_word  <= req_word;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_comb begin
        if (r_state == S_IDLE) begin
            w_accWrite = req_write;
            w_accWord  = req_word;
            w_accAddr  = req_addr;
            w_accWdata = req_wdata;
        end else begin
            w_accWrite = r_write;
            w_accWord  = r_word;
            w_accAddr  = r_addr;
            w_accWdata = r_wdata;
        end
    end

    assign w_accIdx = w_accAddr[c_IDX_W+1:2];
    assign w_lane   = w_accAddr[1:0];

`ifdef DMEM_ERR_EN
    localparam logic [32:0] c_BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    logic r_rspErr;

    assign w_accErr = (w_accWord && (w_lane != 2'd0)) ||
                      ({1'b0, w_accAddr} >= c_BYTE_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rspErr <= 1'b0;
        end else if (w_commit) begin
            r_rspErr <= w_accErr;
        end else if (rsp_valid && rsp_ready) begin
            r_rspErr <= 1'b0;
        end
    end

    assign rsp_err = r_rspErr;
`else
    // Upper address bits are dropped: addresses wrap through the index.
    logic w_unusedAddrHi;
    assign w_unusedAddrHi = ^w_accAddr[31:c_IDX_W+2];
    assign w_accErr       = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Storage and response data
    // ------------------------------------------------------------------------
    assign w_memWord     = r_mem[w_accIdx];
    assign w_laneShifted = w_memWord >> {w_lane, 3'b000};

    always_comb begin
        if (w_accWrite || w_accErr) begin
            w_loadData = 32'd0;
        end else if (w_accWord) begin
            w_loadData = w_memWord;
        end else begin
            w_loadData = {{24{w_laneShifted[7]}}, w_laneShifted[7:0]};
        end
    end

    // Array is deliberately not reset. The reset_n term keeps a request seen
    // while reset is held (zero-wait build) from committing.
    always_ff @(posedge clk) begin
        if (w_commit && reset_n && w_accWrite && !w_accErr) begin
            if (w_accWord) begin
                r_mem[w_accIdx] <= w_accWdata;
            end else begin
                r_mem[w_accIdx][{w_lane, 3'b000} +: 8] <= w_accWdata[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rspRdata <= 32'd0;
        end else if (w_commit) begin
            r_rspRdata <= w_loadData;
        end
    end

    assign rsp_rdata = r_rspRdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. One instance with the
//            default two wait states, one with zero wait states. Responses
//            are compared against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        clk;
    logic        reset_n;

    logic        req_valid, req_ready, req_write, req_word;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write, z_req_word;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int tests_run;
    int tests_failed;

    logic [31:0] model [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_word(z_req_word), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: plain word array, byte lanes by arithmetic.
    // ------------------------------------------------------------------------
    function automatic logic model_err(input logic wd, input logic [31:0] addr);
`ifdef DMEM_ERR_EN
        return (wd && (addr % 4 != 0)) || (64'(addr) >= 64'(DEPTH) * 4);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_apply(input logic wr, input logic wd, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               output logic [31:0] expData, output logic expErr);
        int idx;
        int lane;
        logic [31:0] b;
        idx  = int'((addr / 4) % DEPTH);
        lane = int'(addr % 4);
        expErr  = model_err(wd, addr);
        expData = 32'd0;
        if (!expErr) begin
            if (wr) begin
                if (wd) model[idx] = wdata;
                else    model[idx] = (model[idx] & ~(32'hFF << (8 * lane))) |
                                     ((wdata & 32'hFF) << (8 * lane));
            end else if (wd) begin
                expData = model[idx];
            end else begin
                b = (model[idx] >> (8 * lane)) & 32'hFF;
                expData = (b >= 128) ? (b | 32'hFFFFFF00) : b;
            end
        end
    endtask

    // Drives one request on the WS instance with rsp_ready held high.
    // lat  : negedge samples from acceptance until rsp_valid is seen
    // lowN : negedge samples with req_ready low after acceptance
    task automatic do_access(input logic wr, input logic wd, input logic [31:0] addr,
                             input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int lowN);
        int guard;
        @(negedge clk);
        req_write = wr; req_word = wd; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; lowN = 0;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready !== 1'b1) lowN++;
        end while (rsp_valid !== 1'b1 && lat < 100);
        rdata = rsp_rdata;
        err   = rsp_err;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (req_ready !== 1'b1) lowN++;
        end while (req_ready !== 1'b1 && guard < 100);
        if (lat >= 100 || guard >= 100) begin
            tests_run++; tests_failed++;
            $display("FAIL access_timeout addr=%h lat=%0d guard=%0d (required: response and ready within 100 cycles)",
                     addr, lat, guard);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        tests_run++;
        if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0 || z_rsp_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state_ws0 ready=%b valid=%b rdata=%h required 1 0 00000000",
                     z_req_ready, z_rsp_valid, z_rsp_rdata);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_word_store;
        logic [31:0] d, ed; logic e, ee; int lat, lowN;
        do_access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, d, e, lat, lowN);
        model_apply(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, ed, ee);
        tests_run++;
        if (lat !== WS + 1 || lowN !== WS + 1) begin
            tests_failed++;
            $display("FAIL store_timing lat=%0d readyLow=%0d required %0d %0d", lat, lowN, WS + 1, WS + 1);
        end
        tests_run++;
        if (d !== 32'd0 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_rdata rdata=%h err=%b required 00000000 0", d, e);
        end
        do_access(1'b0, 1'b1, 32'h10, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'hDEADBEEF || lat !== WS + 1) begin
            tests_failed++;
            $display("FAIL word_load rdata=%h lat=%0d required deadbeef %0d", d, lat, WS + 1);
        end
    endtask

    task automatic test_byte_ops;
        logic [31:0] d, ed; logic e, ee; int lat, lowN;
        do_access(1'b1, 1'b1, 32'h20, 32'h11223344, d, e, lat, lowN);
        model_apply(1'b1, 1'b1, 32'h20, 32'h11223344, ed, ee);
        do_access(1'b1, 1'b0, 32'h21, 32'h000000AB, d, e, lat, lowN);
        model_apply(1'b1, 1'b0, 32'h21, 32'h000000AB, ed, ee);
        do_access(1'b0, 1'b1, 32'h20, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'h1122AB44) begin
            tests_failed++;
            $display("FAIL byte_store_merge rdata=%h required 1122ab44", d);
        end
        do_access(1'b0, 1'b0, 32'h21, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'hFFFFFFAB) begin
            tests_failed++;
            $display("FAIL byte_load_neg rdata=%h required ffffffab", d);
        end
        do_access(1'b0, 1'b0, 32'h20, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'h00000044) begin
            tests_failed++;
            $display("FAIL byte_load_pos rdata=%h required 00000044", d);
        end
        do_access(1'b0, 1'b0, 32'h23, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'h00000011) begin
            tests_failed++;
            $display("FAIL byte_load_lane3 rdata=%h required 00000011", d);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d, held, ed; logic e, ee; int guard, lat, lowN;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_write = 1'b0; req_word = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Pending store presented while the load is in flight.
        req_write = 1'b1; req_word = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADCAFE;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (rsp_valid !== 1'b1 && guard < 100);
        held = rsp_rdata;
        tests_run++;
        if (held !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bp_load_data rdata=%h required deadbeef", held);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cycle=%0d valid=%b rdata=%h ready=%b required 1 %h 0",
                         i, rsp_valid, rsp_rdata, req_ready, held);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_pending_accept ready=%b required 0", req_ready);
        end
        req_valid = 1'b0;
        model_apply(1'b1, 1'b1, 32'h30, 32'h0BADCAFE, ed, ee);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (rsp_valid !== 1'b1 && guard < 100);
        tests_run++;
        if (rsp_rdata !== 32'd0 || guard >= 100) begin
            tests_failed++;
            $display("FAIL bp_store_rsp rdata=%h waited=%0d required 00000000 within 100", rsp_rdata, guard);
        end
        do_access(1'b0, 1'b1, 32'h30, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'h0BADCAFE) begin
            tests_failed++;
            $display("FAIL bp_store_readback rdata=%h required 0badcafe", d);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] d, ed; logic e, ee; int lat, lowN;
        do_access(1'b1, 1'b1, 32'h40, 32'h13572468, d, e, lat, lowN);
        model_apply(1'b1, 1'b1, 32'h40, 32'h13572468, ed, ee);
        @(negedge clk);
        req_write = 1'b1; req_word = 1'b1; req_addr = 32'h40; req_wdata = 32'h00000055;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_wait valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_access(1'b0, 1'b1, 32'h40, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'h13572468) begin
            tests_failed++;
            $display("FAIL reset_drops_store rdata=%h required 13572468", d);
        end
    endtask

    task automatic test_random;
        logic [31:0] d, ed, a, w; logic e, ee, wr, wd; int lat, lowN;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            do_access(1'b1, 1'b1, 32'h200 + 32'(i * 4), w, d, e, lat, lowN);
            model_apply(1'b1, 1'b1, 32'h200 + 32'(i * 4), w, ed, ee);
        end
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            a  = 32'h200 + 32'($urandom_range(0, 255));
            if (wd) a = a & 32'hFFFFFFFC;
            w  = $urandom;
            do_access(wr, wd, a, w, d, e, lat, lowN);
            model_apply(wr, wd, a, w, ed, ee);
            tests_run++;
            if (d !== ed || e !== ee || lat !== WS + 1) begin
                tests_failed++;
                $display("FAIL random op=%0d wr=%b wd=%b addr=%h rdata=%h err=%b lat=%0d required %h %b %0d",
                         i, wr, wd, a, d, e, lat, ed, ee, WS + 1);
            end
        end
    endtask

    task automatic test_addr_edges;
        logic [31:0] d, ed; logic e, ee; int lat, lowN;
        do_access(1'b1, 1'b1, 32'h0, 32'hA5A55A5A, d, e, lat, lowN);
        model_apply(1'b1, 1'b1, 32'h0, 32'hA5A55A5A, ed, ee);
`ifdef DMEM_ERR_EN
        do_access(1'b1, 1'b1, 32'h42, 32'hFFFFFFFF, d, e, lat, lowN);
        model_apply(1'b1, 1'b1, 32'h42, 32'hFFFFFFFF, ed, ee);
        tests_run++;
        if (e !== 1'b1 || d !== 32'd0) begin
            tests_failed++;
            $display("FAIL err_misaligned err=%b rdata=%h required 1 00000000", e, d);
        end
        do_access(1'b0, 1'b1, 32'h40, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'h13572468 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_no_write rdata=%h err=%b required 13572468 0", d, e);
        end
        do_access(1'b0, 1'b1, 32'(DEPTH * 4), 32'h0, d, e, lat, lowN);
        tests_run++;
        if (e !== 1'b1 || d !== 32'd0) begin
            tests_failed++;
            $display("FAIL err_range err=%b rdata=%h required 1 00000000", e, d);
        end
`else
        do_access(1'b0, 1'b1, 32'(DEPTH * 4), 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'hA5A55A5A || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL addr_wrap rdata=%h err=%b required a5a55a5a 0", d, e);
        end
        do_access(1'b0, 1'b1, 32'h13, 32'h0, d, e, lat, lowN);
        tests_run++;
        if (d !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_ignores_low_bits rdata=%h required deadbeef", d);
        end
`endif
    endtask

    task automatic test_zero_wait;
        int accepts, rsps, bad;
        z_rsp_ready = 1'b1;
        @(negedge clk);
        z_req_write = 1'b1; z_req_word = 1'b1; z_req_addr = 32'h10; z_req_wdata = 32'hCAFEF00D;
        z_req_valid = 1'b1;
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL ws0_store_latency valid=%b rdata=%h required 1 00000000", z_rsp_valid, z_rsp_rdata);
        end
        @(negedge clk);
        z_req_write = 1'b0; z_req_addr = 32'h10;
        z_req_valid = 1'b1;
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL ws0_load valid=%b rdata=%h required 1 cafef00d", z_rsp_valid, z_rsp_rdata);
        end
        @(negedge clk);
        accepts = 0; rsps = 0; bad = 0;
        z_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (z_req_ready === 1'b1) accepts++;
            if (z_rsp_valid === 1'b1) begin
                rsps++;
                if (z_rsp_rdata !== 32'hCAFEF00D) bad++;
            end
        end
        z_req_valid = 1'b0;
        @(posedge clk);
        tests_run++;
        if (accepts !== 5 || rsps !== 5 || bad !== 0) begin
            tests_failed++;
            $display("FAIL ws0_back_to_back accepts=%0d rsps=%0d baddata=%0d required 5 5 0", accepts, rsps, bad);
        end
        tests_run++;
        if (z_rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ws0_err err=%b required 0", z_rsp_err);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_word = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
        z_rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'hx;

        test_reset;
        test_word_store;
        test_byte_ops;
        test_backpressure;
        test_reset_mid_wait;
        test_zero_wait;
        test_addr_edges;
        test_random;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t required finish before 2000000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
